// File: rtl/div_ratio_ctrl_pkg.sv
// Shared types and constants for the divider ratio controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package div_ctrl_pkg;

  localparam int CNT_W_DEF = 4;
  localparam int MIN_RATIO = 2;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    PEND   = 2'd1,
    SETTLE = 2'd2
  } state_t;

endpackage

// File: rtl/div_ratio_ctrl_if.sv
// Ratio request channel between a requester and the divider controller.
// Latency: n/a (wires only).
// Backpressure: requester holds req_valid/req_ratio stable until req_ready is seen.
interface div_ratio_ctrl_if #(
  parameter int CNT_W = 4
);

  logic             req_valid;
  logic [CNT_W-1:0] req_ratio;
  logic             req_ready;

  modport master (output req_valid, output req_ratio, input req_ready);
  modport slave  (input req_valid, input req_ratio, output req_ready);

endinterface

// File: rtl/div_ratio_cnt.sv
// Divide counter with wrap/enable hold and tc/div_hi/ratio_odd decode.
// Latency: decodes are combinational from the counter flop (zero added latency).
// Backpressure: none; counts every enabled cycle.
module div_ratio_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             gate,
  input  logic [CNT_W-1:0] ratio,
  output logic [CNT_W-1:0] cnt,
  output logic             at_term,
  output logic             tc,
  output logic             div_hi,
  output logic             ratio_odd
);

  logic [CNT_W-1:0] cnt_q;
  logic             last;
  logic [CNT_W:0]   half;

  // Last count of the current period under the active ratio.
  assign last = (cnt_q == (ratio - {{(CNT_W-1){1'b0}}, 1'b1}));

  // High phase covers ceil(ratio/2) counts so odd ratios get the longer half.
  assign half = ({1'b0, ratio} + {{CNT_W{1'b0}}, 1'b1}) >> 1;

  // Count up, wrap after ratio-1, park at 0 while disabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (!en || last) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign cnt       = cnt_q;
  assign at_term   = en & ~rst & last;
  assign tc        = at_term & ~gate;
  assign div_hi    = en & ~rst & ~gate & ({1'b0, cnt_q} < half);
  assign ratio_odd = ratio[0];

endmodule

// File: rtl/div_ratio_ctrl.sv
// Run-time divide-ratio controller: applies new ratios only at the period boundary.
// Latency: ratio takes effect on the terminal-count edge (next edge if disabled), err one cycle after accept.
// Backpressure: req_ready low outside RUN; optional DIV_RATIO_CTRL_GATE_EN masks tc/div_hi in SETTLE.
module div_ratio_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int DEF_RATIO  = 9,
  parameter int SETTLE_CYC = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  div_en,
  div_ratio_ctrl_if.slave       req,
  output logic [CNT_W-1:0]      cur_ratio,
  output logic [CNT_W-1:0]      cnt,
  output logic                  tc,
  output logic                  div_hi,
  output logic                  ratio_odd,
  output logic                  busy,
  output logic                  err
);

  localparam int SC_W = $clog2(SETTLE_CYC + 1);
  localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] RATIO_RST = CNT_W'(DEF_RATIO);
  localparam logic [CNT_W-1:0] RATIO_MIN = CNT_W'(MIN_RATIO);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cur_q, cur_nxt;
  logic [CNT_W-1:0] pend_q, pend_nxt;
  logic [SC_W-1:0]  scnt_q, scnt_nxt;
  logic             err_q, err_nxt;
  logic             ready;
  logic             xfer;
  logic             at_term;
  logic             gate;

  assign ready         = (state == RUN) & ~rst;
  assign xfer          = req.req_valid & ready;
  assign req.req_ready = ready;

`ifdef DIV_RATIO_CTRL_GATE_EN
  assign gate = (state == SETTLE);
`else
  assign gate = 1'b0;
`endif

  // Controller state, active/pending ratio, settle timer and error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RUN;
      cur_q  <= RATIO_RST;
      pend_q <= RATIO_RST;
      scnt_q <= '0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      cur_q  <= cur_nxt;
      pend_q <= pend_nxt;
      scnt_q <= scnt_nxt;
      err_q  <= err_nxt;
    end
  end

  // Next-state: accept in RUN, swap ratio at the period boundary, then settle.
  always_comb begin
    state_nxt = state;
    cur_nxt   = cur_q;
    pend_nxt  = pend_q;
    scnt_nxt  = scnt_q;
    err_nxt   = 1'b0;
    case (state)
      RUN: begin
        if (xfer) begin
          if (req.req_ratio < RATIO_MIN) begin
            err_nxt = 1'b1;
          end else if (req.req_ratio != cur_q) begin
            pend_nxt  = req.req_ratio;
            state_nxt = PEND;
          end
        end
      end
      PEND: begin
        // Counter wraps to 0 on its own at the terminal edge, or is parked at 0 when disabled.
        if (!div_en || at_term) begin
          cur_nxt   = pend_q;
          scnt_nxt  = '0;
          state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        if (scnt_q == SC_LAST) begin
          state_nxt = RUN;
        end else begin
          scnt_nxt = scnt_q + {{(SC_W-1){1'b0}}, 1'b1};
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  div_ratio_cnt #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .en       (div_en),
    .gate     (gate),
    .ratio    (cur_q),
    .cnt      (cnt),
    .at_term  (at_term),
    .tc       (tc),
    .div_hi   (div_hi),
    .ratio_odd(ratio_odd)
  );

  assign cur_ratio = cur_q;
  assign busy      = (state != RUN) & ~rst;
  assign err       = err_q & ~rst;

endmodule

// File: tb/tb_div_ratio_ctrl.sv
// Randomised and directed bench for div_ratio_ctrl with a scoreboard queue.
// Expected outputs come from a period-level model of the ratio controller.
// A negedge monitor pops one expectation per cycle and compares every output.
module tb_div_ratio_ctrl;

  localparam int CW  = 4;
  localparam int DEF = 9;
  localparam int SC  = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          div_en;
  logic [CW-1:0] cur_ratio;
  logic [CW-1:0] cnt;
  logic          tc, div_hi, ratio_odd, busy, err;

  always #5 clk = ~clk;

  div_ratio_ctrl_if #(.CNT_W(CW)) req_if ();

  div_ratio_ctrl #(
    .CNT_W(CW),
    .DEF_RATIO(DEF),
    .SETTLE_CYC(SC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .div_en   (div_en),
    .req      (req_if),
    .cur_ratio(cur_ratio),
    .cnt      (cnt),
    .tc       (tc),
    .div_hi   (div_hi),
    .ratio_odd(ratio_odd),
    .busy     (busy),
    .err      (err)
  );

  typedef struct packed {
    logic          ready;
    logic          busy;
    logic          err;
    logic          tc;
    logic          hi;
    logic          odd;
    logic [CW-1:0] cur;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc_n    = 0;

  // Reference model: active ratio, position inside the period, pending ratio
  // (0 = none), remaining settle cycles, error pulse to show this cycle.
  int m_cur, m_pos, m_pend, m_settle;
  bit m_err;
  // Inputs applied during the current cycle.
  bit a_rst, a_en, a_v;
  int a_ra;

  function automatic bit model_ready();
    return (m_pend == 0) && (m_settle == 0);
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    bit   masked;
`ifdef DIV_RATIO_CTRL_GATE_EN
    masked = (m_settle > 0);
`else
    masked = 1'b0;
`endif
    e.cur = m_cur[CW-1:0];
    e.cnt = m_pos[CW-1:0];
    e.odd = (m_cur % 2) == 1;
    if (a_rst) begin
      e.ready = 0; e.busy = 0; e.err = 0; e.tc = 0; e.hi = 0;
    end else begin
      e.ready = model_ready();
      e.busy  = !model_ready();
      e.err   = m_err;
      e.tc    = a_en && (m_pos == m_cur - 1) && !masked;
      e.hi    = a_en && (m_pos < (m_cur + 1) / 2) && !masked;
    end
    return e;
  endfunction

  function automatic void model_step();
    bit rdy, xfer, term;
    int nxt_pos;
    if (a_rst) begin
      m_cur = DEF; m_pos = 0; m_pend = 0; m_settle = 0; m_err = 0;
      return;
    end
    rdy     = model_ready();
    xfer    = rdy && a_v;
    term    = a_en && (m_pos == m_cur - 1);
    nxt_pos = (!a_en || term) ? 0 : m_pos + 1;
    m_err   = xfer && (a_ra < 2);
    if (m_pend != 0) begin
      if (!a_en || term) begin
        m_cur    = m_pend;
        m_pend   = 0;
        m_settle = SC;
      end
    end else if (m_settle > 0) begin
      m_settle = m_settle - 1;
    end else if (xfer && a_ra >= 2 && a_ra != m_cur) begin
      m_pend = a_ra;
    end
    m_pos = nxt_pos;
  endfunction

  // One clock of stimulus; the request is only raised when the counter is at at_pos (or always if at_pos<0).
  task automatic cyc(input bit r, input bit e, input bit v, input int ra, input int at_pos,
                     output bit fired);
    bit vv;
    @(posedge clk);
    model_step();
    #1;
    vv = v && (at_pos < 0 || m_pos == at_pos);
    rst              = r;
    div_en           = e;
    req_if.req_valid = vv;
    req_if.req_ratio = ra[CW-1:0];
    a_rst = r; a_en = e; a_v = vv; a_ra = ra;
    fired = vv && !r && model_ready();
    q.push_back(model_out());
  endtask

  task automatic idle(input bit e, input int n);
    bit f;
    for (int i = 0; i < n; i++) cyc(0, e, 0, 0, -1, f);
  endtask

  // Issue a request when the counter is at pos; an expired budget counts as a failure.
  task automatic req_at(input int pos, input int ra, input bit e);
    bit f;
    f = 0;
    for (int i = 0; i < 40 && !f; i++) cyc(0, e, 1, ra, pos, f);
    checks++;
    if (!f) begin
      failures++;
      $display("FAIL req_accept ratio=%0d pos=%0d got=not_accepted exp=accepted", ra, pos);
    end
  endtask

  function automatic void chk(input string n, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", n, cyc_n, got, exp);
    end
  endfunction

  // Monitor: one expectation per cycle, compared away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      cyc_n++;
      chk("req_ready", {7'd0, req_if.req_ready}, {7'd0, e.ready});
      chk("busy",      {7'd0, busy},             {7'd0, e.busy});
      chk("err",       {7'd0, err},              {7'd0, e.err});
      chk("tc",        {7'd0, tc},               {7'd0, e.tc});
      chk("div_hi",    {7'd0, div_hi},           {7'd0, e.hi});
      chk("ratio_odd", {7'd0, ratio_odd},        {7'd0, e.odd});
      chk("cur_ratio", {4'd0, cur_ratio},        {4'd0, e.cur});
      chk("cnt",       {4'd0, cnt},              {4'd0, e.cnt});
    end
  end

  initial begin
    bit f;
    bit hv;
    int hr;
    rst              = 1'b1;
    div_en           = 1'b0;
    req_if.req_valid = 1'b0;
    req_if.req_ratio = '0;
    a_rst = 1; a_en = 0; a_v = 0; a_ra = 0;
    m_cur = DEF; m_pos = 0; m_pend = 0; m_settle = 0; m_err = 0;
    repeat (2) @(posedge clk);

    // Reset held with enable high, then free-running at the default ratio.
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, -1, f);
    idle(1, 20);

    // Illegal ratios 1 and 0, then same-ratio request.
    req_at(2, 1, 1);
    idle(1, 5);
    req_at(6, 0, 1);
    idle(1, 5);
    req_at(4, 9, 1);
    idle(1, 12);

    // Ratio 4 requested at cnt=3 of the ratio-9 period.
    req_at(3, 4, 1);
    idle(1, 16);

    // Disabled switch to 6, then re-enable.
    idle(0, 3);
    req_at(0, 6, 0);
    idle(0, 4);
    idle(1, 20);

    // Reset while a switch to 5 is pending.
    req_at(1, 5, 1);
    cyc(1, 1, 0, 0, -1, f);
    cyc(1, 1, 0, 0, -1, f);
    idle(1, 12);

    // Random traffic; requester holds its data until accepted.
    hv = 0;
    hr = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!hv && $urandom_range(3) == 0) begin
        hv = 1;
        hr = $urandom_range(15);
      end
      cyc(($urandom_range(199) == 0), ($urandom_range(9) != 0), hv, hr, -1, f);
      if (f) hv = 0;
    end
    idle(1, 2);

    repeat (2) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d exp=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
